// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the receive path: symbol width, word-aligner state
// encoding and default lock/unlock thresholds.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rx_pkg;

  // Width of one line-coded symbol
  localparam int WORD_W = 10;

  // Width of the bit-within-symbol counter (0..WORD_W-1)
  localparam int BITCNT_W = 4;

  // Default thresholds for the word-alignment state machine
  localparam int LOCK_COUNT_DEF   = 3;
  localparam int UNLOCK_COUNT_DEF = 4;

  // Word-alignment state machine encoding
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

endpackage : rx_pkg

`default_nettype wire

// File: rtl/rx_word_aligner.sv
// ---------------------------------------------------------------------------
// rx_word_aligner
// Frames a recovered serial bit stream into 10-bit symbols. Comma strobes
// from the upstream detector set the symbol phase; a HUNT/SYNC/LOCKED state
// machine qualifies the alignment and guards it against isolated bit errors.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_word_aligner
  import rx_pkg::*;
#(
  parameter int COMMA_PHASE  = 6,
  parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
  parameter int UNLOCK_COUNT = UNLOCK_COUNT_DEF
) (
  input  logic              BitCLK,
  input  logic              Reset,
  input  logic              Serial,
  input  logic              Comma,
  output logic [WORD_W-1:0] Data,
  output logic              DataValid,
  output logic              Locked,
  output logic              Realign
);

  // Counter value at which a comma is expected when the phase is correct:
  // one edge before the counter would have been reloaded with COMMA_PHASE.
  localparam logic [BITCNT_W-1:0] C_IN_PHASE = BITCNT_W'((COMMA_PHASE + WORD_W - 1) % WORD_W);
  localparam logic [BITCNT_W-1:0] C_PHASE    = BITCNT_W'(COMMA_PHASE);
  localparam logic [BITCNT_W-1:0] C_LAST_BIT = BITCNT_W'(WORD_W - 1);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] C_MATCH_SAT = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  C_MISS_SAT  = MISS_W'(UNLOCK_COUNT);
  localparam logic [MATCH_W-1:0] C_MATCH_ONE = MATCH_W'(1);
  localparam logic [MISS_W-1:0]  C_MISS_ONE  = MISS_W'(1);

  align_state_e         state_q, state_d;
  logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]    shreg_q, shreg_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]    miss_q, miss_d;

  logic [WORD_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 realign_q, realign_d;

  logic                 comma_in_phase;
  logic                 comma_out_phase;
  logic                 word_boundary;

  assign comma_in_phase  = Comma && (bitcnt_q == C_IN_PHASE);
  assign comma_out_phase = Comma && (bitcnt_q != C_IN_PHASE);
  // A symbol completes on the edge where the counter sits at its last bit,
  // but only once a comma has given us a phase to trust.
  assign word_boundary   = (bitcnt_q == C_LAST_BIT) &&
                           ((state_q == ST_SYNC) || (state_q == ST_LOCKED));

  // State register plus alignment datapath registers
  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_HUNT;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      match_q  <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
    end
  end

  // Next-state logic: state transitions, qualification counts, bit counter
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    miss_d    = miss_q;
    realign_d = 1'b0;
    shreg_d   = {shreg_q[WORD_W-2:0], Serial};
    bitcnt_d  = (bitcnt_q == C_LAST_BIT) ? '0 : bitcnt_q + 1'b1;

    unique case (state_q)
      ST_HUNT: begin
        if (Comma) begin
          realign_d = 1'b1;
          match_d   = C_MATCH_ONE;
          miss_d    = '0;
          state_d   = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (comma_in_phase) begin
          if (match_q != C_MATCH_SAT) begin
            match_d = match_q + 1'b1;
          end
          if ((match_q + 1'b1) >= C_MATCH_SAT) begin
            state_d = ST_LOCKED;
            miss_d  = '0;
          end
        end else if (comma_out_phase) begin
          realign_d = 1'b1;
          match_d   = C_MATCH_ONE;
        end
      end

      ST_LOCKED: begin
        // Once locked the phase is never moved; bad commas only count.
        if (comma_in_phase) begin
          miss_d = '0;
        end else if (comma_out_phase) begin
          if (miss_q != C_MISS_SAT) begin
            miss_d = miss_q + 1'b1;
          end
          if ((miss_q + 1'b1) >= C_MISS_SAT) begin
            state_d = ST_HUNT;
            match_d = '0;
            miss_d  = '0;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
        match_d = '0;
        miss_d  = '0;
      end
    endcase

    // A realign wins over the normal wrap, even on a word boundary.
    if (realign_d) begin
      bitcnt_d = C_PHASE;
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    data_d   = data_q;
    valid_d  = 1'b0;
    if (word_boundary) begin
      data_d  = {shreg_q[WORD_W-2:0], Serial};
      valid_d = 1'b1;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Output registers
  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      realign_q <= realign_d;
    end
  end

  assign Data      = data_q;
  assign DataValid = valid_q;
  assign Locked    = locked_q;
  assign Realign   = realign_q;

endmodule : rx_word_aligner

`default_nettype wire

// File: tb/tb_rx_word_aligner.sv
// ---------------------------------------------------------------------------
// tb_rx_word_aligner
// Directed bench for rx_word_aligner: expected symbols are queued as they are
// sent and a monitor checks every DataValid strobe against the queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_word_aligner;
  import rx_pkg::*;

  logic        BitCLK = 1'b0;
  logic        Reset  = 1'b0;
  logic        Serial = 1'b0;
  logic        Comma  = 1'b0;
  logic [9:0]  Data;
  logic        DataValid;
  logic        Locked;
  logic        Realign;

  int          n_vec = 0;
  int          n_err = 0;
  logic [9:0]  exp_q[$];

  localparam logic [9:0] K_NEG = 10'h0FA;  // 0011111010
  localparam logic [9:0] K_POS = 10'h305;  // 1100000101

  rx_word_aligner #(
    .COMMA_PHASE (6),
    .LOCK_COUNT  (3),
    .UNLOCK_COUNT(4)
  ) dut (
    .BitCLK   (BitCLK),
    .Reset    (Reset),
    .Serial   (Serial),
    .Comma    (Comma),
    .Data     (Data),
    .DataValid(DataValid),
    .Locked   (Locked),
    .Realign  (Realign)
  );

  always #5 BitCLK = ~BitCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One bit per clock: drive just after an edge, leave the DUT settled 1 ns
  // after the following edge.
  task automatic step(input logic s, input logic c);
    Serial = s;
    Comma  = c;
    @(posedge BitCLK);
    #1;
  endtask

  // Send a symbol MSB first, raising Comma on bit index cpos (-1: none).
  task automatic send_word(input logic [9:0] w, input int cpos, input bit expect_out);
    if (expect_out) exp_q.push_back(w);
    for (int i = 0; i < 10; i++) step(w[9-i], (i == cpos));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
      check("no_valid_idle", {31'd0, DataValid}, 32'd0);
    end
  endtask

  // Scoreboard monitor
  always @(posedge BitCLK) begin
    #1;
    if (DataValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got Data 0x%0h, want no strobe at %0t", Data, $time);
      end else begin
        check("data_word", {22'd0, Data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge BitCLK);
    #1;
    check("rst_data",    {22'd0, Data},      32'd0);
    check("rst_valid",   {31'd0, DataValid}, 32'd0);
    check("rst_locked",  {31'd0, Locked},    32'd0);
    check("rst_realign", {31'd0, Realign},   32'd0);
    Reset = 1'b1;

    // HUNT: no symbols without a comma
    idle(15);
    check("hunt_locked", {31'd0, Locked}, 32'd0);

    // First comma: realign pulse, counter reloaded, SYNC
    exp_q.push_back(K_NEG);
    for (int i = 0; i < 5; i++) step(K_NEG[9-i], 1'b0);
    step(K_NEG[4], 1'b1);
    check("realign_pulse", {31'd0, Realign}, 32'd1);
    check("cnt_after_realign", {28'd0, dut.bitcnt_q}, 32'd6);
    check("state_sync", {30'd0, dut.state_q}, {30'd0, ST_SYNC});
    check("sync_locked", {31'd0, Locked}, 32'd0);
    step(K_NEG[3], 1'b0);
    check("realign_one_cycle", {31'd0, Realign}, 32'd0);
    for (int i = 7; i < 10; i++) step(K_NEG[9-i], 1'b0);

    // Second and third in-phase commas -> lock
    send_word(K_NEG, 5, 1'b1);
    check("locked_after_2", {31'd0, Locked}, 32'd0);
    exp_q.push_back(K_POS);
    for (int i = 0; i < 5; i++) step(K_POS[9-i], 1'b0);
    step(K_POS[4], 1'b1);
    check("locked_after_3", {31'd0, Locked}, 32'd1);
    for (int i = 6; i < 10; i++) step(K_POS[9-i], 1'b0);

    // Locked K28.5 stream, both disparities
    send_word(K_NEG, 5, 1'b1);
    send_word(K_POS, 5, 1'b1);
    send_word(K_NEG, 5, 1'b1);
    send_word(K_POS, -1, 1'b1);

    // Three misses then an in-phase comma clears the miss count
    send_word(K_NEG, 2, 1'b1);
    send_word(K_POS, 2, 1'b1);
    send_word(K_NEG, 8, 1'b1);
    check("locked_miss3", {31'd0, Locked}, 32'd1);
    send_word(K_POS, 5, 1'b1);
    send_word(K_NEG, 2, 1'b1);
    send_word(K_POS, 2, 1'b1);
    send_word(K_NEG, 2, 1'b1);
    check("locked_after_clear", {31'd0, Locked}, 32'd1);
    send_word(K_POS, 5, 1'b1);

    // Four consecutive misses drop lock; the fourth word is not emitted
    send_word(K_NEG, 2, 1'b1);
    send_word(K_POS, 2, 1'b1);
    send_word(K_NEG, 2, 1'b1);
    for (int i = 0; i < 2; i++) step(K_POS[9-i], 1'b0);
    step(K_POS[7], 1'b1);
    check("unlock_locked", {31'd0, Locked}, 32'd0);
    check("unlock_state", {30'd0, dut.state_q}, {30'd0, ST_HUNT});
    for (int i = 3; i < 10; i++) step(K_POS[9-i], 1'b0);
    idle(20);

    // Relock, then asynchronous reset mid-word
    send_word(K_NEG, 5, 1'b1);
    send_word(K_POS, 5, 1'b1);
    send_word(K_NEG, 5, 1'b1);
    check("relock", {31'd0, Locked}, 32'd1);
    for (int i = 0; i < 4; i++) step(K_POS[9-i], 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    check("arst_data",    {22'd0, Data},      32'd0);
    check("arst_valid",   {31'd0, DataValid}, 32'd0);
    check("arst_locked",  {31'd0, Locked},    32'd0);
    check("arst_realign", {31'd0, Realign},   32'd0);
    check("arst_cnt",     {28'd0, dut.bitcnt_q}, 32'd0);
    @(posedge BitCLK);
    #1;
    Reset = 1'b1;
    idle(20);

    // Out-of-phase comma on the word boundary while in SYNC
    send_word(K_NEG, 5, 1'b1);
    exp_q.push_back(K_NEG);
    for (int i = 0; i < 9; i++) step(K_NEG[9-i], 1'b0);
    step(K_NEG[0], 1'b1);
    check("boundary_realign", {31'd0, Realign}, 32'd1);
    check("boundary_cnt", {28'd0, dut.bitcnt_q}, 32'd6);
    // Next symbol completes four bits later: {111010, 1010}
    exp_q.push_back(10'h3AA);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);
    check("boundary_locked", {31'd0, Locked}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rx_word_aligner

`default_nettype wire
